// File: rtl/div_hilo_ctrl.sv
// Purpose: EX-stage controller for DIV/DIVU/MTHI/MTLO; owns architectural HI/LO and drives the iterative divider.
// Latency: MTHI/MTLO visible one edge after EX; a DIV commits HI/LO at the div_end edge and retires one cycle later (DONE).
// Backpressure: ex_stall holds EX from launch until DONE; a flush aborts and blocks launches/moves for ABORT_CYCLES cycles.
module div_hilo_ctrl #(
  parameter int unsigned ABORT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_rs_val,
  input  logic [31:0] ex_rt_val,
  input  logic        ex_flush,
  output logic        ex_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        div_begin,
  output logic        div_unsigned,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  input  logic [63:0] div_product,
  input  logic        div_end
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;

  // Last counter value spent in ABORT before returning to IDLE.
  localparam logic [1:0] ABORT_LAST = 2'(ABORT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        div_begin_q, div_begin_d;
  logic        div_unsigned_q, div_unsigned_d;
  logic [31:0] div_op1_q, div_op1_d;
  logic [31:0] div_op2_q, div_op2_d;
  logic        busy_q, busy_d;

  logic op_is_div;
  logic op_is_known;
  logic is_div;
  logic is_mthi;
  logic is_mtlo;

  // Instruction decode; encodings above MTLO behave like "none".
  always_comb begin
    op_is_div   = (ex_op == OP_DIV) || (ex_op == OP_DIVU);
    op_is_known = (ex_op >= OP_DIV) && (ex_op <= OP_MTLO);
    is_div      = ex_valid && op_is_div && !ex_flush;
    is_mthi     = ex_valid && (ex_op == OP_MTHI) && !ex_flush;
    is_mtlo     = ex_valid && (ex_op == OP_MTLO) && !ex_flush;
  end

  // Stall is purely combinational from the EX inputs and the current state.
  always_comb begin
    ex_stall = 1'b0;
    unique case (state_q)
      ST_IDLE:  ex_stall = is_div;
      ST_BUSY:  ex_stall = !ex_flush;           // a flush releases the pipe immediately
      ST_DONE:  ex_stall = 1'b0;                // held DIV retires here
      ST_ABORT: ex_stall = ex_valid && op_is_known;
      default:  ex_stall = 1'b0;
    endcase
  end

  // Next-state and register-update logic; flush always wins over div_end.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    hi_d           = hi_q;
    lo_d           = lo_q;
    div_begin_d    = div_begin_q;
    div_unsigned_d = div_unsigned_q;
    div_op1_d      = div_op1_q;
    div_op2_d      = div_op2_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = 2'd0;
        if (is_div) begin
          div_op1_d      = ex_rs_val;
          div_op2_d      = ex_rt_val;
          div_unsigned_d = (ex_op == OP_DIVU);
          div_begin_d    = 1'b1;
          state_d        = ST_BUSY;
        end else if (is_mthi) begin
          hi_d = ex_rs_val;
        end else if (is_mtlo) begin
          lo_d = ex_rs_val;
        end
      end

      ST_BUSY: begin
        if (ex_flush) begin
          // Drop the request; any completion from here on is stale.
          div_begin_d = 1'b0;
          cnt_d       = 2'd0;
          state_d     = ST_ABORT;
        end else if (div_end) begin
          hi_d        = div_product[63:32];
          lo_d        = div_product[31:0];
          div_begin_d = 1'b0;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        // ex_op still shows the retiring DIV; do not reissue it.
        div_begin_d = 1'b0;
        state_d     = ST_IDLE;
      end

      ST_ABORT: begin
        div_begin_d = 1'b0;
        if (cnt_q == ABORT_LAST) begin
          cnt_d   = 2'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      default: begin
        div_begin_d = 1'b0;
        cnt_d       = 2'd0;
        state_d     = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, HI/LO and divider-facing registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 2'd0;
      hi_q           <= 32'd0;
      lo_q           <= 32'd0;
      div_begin_q    <= 1'b0;
      div_unsigned_q <= 1'b0;
      div_op1_q      <= 32'd0;
      div_op2_q      <= 32'd0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      hi_q           <= hi_d;
      lo_q           <= lo_d;
      div_begin_q    <= div_begin_d;
      div_unsigned_q <= div_unsigned_d;
      div_op1_q      <= div_op1_d;
      div_op2_q      <= div_op2_d;
      busy_q         <= busy_d;
    end
  end

  assign hi           = hi_q;
  assign lo           = lo_q;
  assign busy         = busy_q;
  assign div_begin    = div_begin_q;
  assign div_unsigned = div_unsigned_q;
  assign div_op1      = div_op1_q;
  assign div_op2      = div_op2_q;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Purpose: self-checking bench for div_hilo_ctrl with a bench-side divider and HI/LO scoreboard.
// Latency: inputs driven at negedge, outputs sampled 1ns later, away from the rising edge.
// Backpressure: EX inputs are held by the bench for as long as ex_stall is expected high.
module tb_div_hilo_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_rs_val;
  logic [31:0] ex_rt_val;
  logic        ex_flush;
  logic        ex_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        div_begin;
  logic        div_unsigned;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic [63:0] div_product;
  logic        div_end;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] sb_q[$];

  div_hilo_ctrl #(.ABORT_CYCLES(2)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ex_valid     (ex_valid),
    .ex_op        (ex_op),
    .ex_rs_val    (ex_rs_val),
    .ex_rt_val    (ex_rt_val),
    .ex_flush     (ex_flush),
    .ex_stall     (ex_stall),
    .hi           (hi),
    .lo           (lo),
    .busy         (busy),
    .div_begin    (div_begin),
    .div_unsigned (div_unsigned),
    .div_op1      (div_op1),
    .div_op2      (div_op2),
    .div_product  (div_product),
    .div_end      (div_end)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  // Reference divider: {remainder, quotient}, truncating toward zero.
  function automatic logic [63:0] div_ref(input logic uns, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (uns) begin
      q = a / b;
      r = a % b;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
    return {r, q};
  endfunction

  task automatic sb_check(input string tag);
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
    end else begin
      e = sb_q.pop_front();
      chk(tag, {hi, lo}, e);
    end
  endtask

  // Runs a DIV already accepted this cycle (state about to go BUSY) through to IDLE.
  task automatic finish_div(input string tag, input logic uns, input logic [31:0] a,
                            input logic [31:0] b, input int lat);
    logic        stall_ok;
    logic        beg_ok;
    logic        stab_ok;
    logic [63:0] e;
    e = div_ref(uns, a, b);
    sb_q.push_back(e);
    m_hi = e[63:32];
    m_lo = e[31:0];
    stall_ok = 1'b1;
    beg_ok   = 1'b1;
    stab_ok  = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      div_end     = (k == lat);
      div_product = (k == lat) ? div_ref(div_unsigned, div_op1, div_op2) : 64'hDEAD_BEEF_0BAD_F00D;
      #1;
      if (ex_stall !== 1'b1) stall_ok = 1'b0;
      if (div_begin !== 1'b1 || busy !== 1'b1) beg_ok = 1'b0;
      if (div_op1 !== a || div_op2 !== b || div_unsigned !== uns) stab_ok = 1'b0;
    end
    chk({tag, "_busy_stall"}, 64'(stall_ok), 64'd1);
    chk({tag, "_busy_begin"}, 64'(beg_ok), 64'd1);
    chk({tag, "_ops_stable"}, 64'(stab_ok), 64'd1);
    @(negedge clk);
    div_end     = 1'b0;
    div_product = 64'd0;
    #1;
    chk({tag, "_done_stall"}, 64'(ex_stall), 64'd0);
    chk({tag, "_done_begin"}, 64'(div_begin), 64'd0);
    chk({tag, "_done_busy"}, 64'(busy), 64'd1);
    sb_check({tag, "_hilo"});
    @(negedge clk);
    ex_valid = 1'b0;
    ex_op    = 3'b000;
    #1;
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_begin"}, 64'(div_begin), 64'd0);
  endtask

  task automatic do_div(input string tag, input logic uns, input logic [31:0] a,
                        input logic [31:0] b, input int lat);
    @(negedge clk);
    ex_valid  = 1'b1;
    ex_op     = uns ? 3'b010 : 3'b001;
    ex_rs_val = a;
    ex_rt_val = b;
    ex_flush  = 1'b0;
    #1;
    chk({tag, "_stall_t"}, 64'(ex_stall), 64'd1);
    chk({tag, "_begin_t"}, 64'(div_begin), 64'd0);
    finish_div(tag, uns, a, b, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    ex_valid = 1'b0; ex_op = 3'b000; ex_rs_val = 32'd0; ex_rt_val = 32'd0;
    ex_flush = 1'b0; div_end = 1'b0; div_product = 64'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_begin", 64'(div_begin), 64'd0);
    chk("rst_uns", 64'(div_unsigned), 64'd0);
    chk("rst_ops", {div_op1, div_op2}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_stall", 64'(ex_stall), 64'd0);

    // Signed and unsigned divides with the slow divider.
    do_div("div_s", 1'b0, 32'hFFFF_FFF9, 32'd2, 34);
    do_div("divu", 1'b1, 32'hFFFF_FFF9, 32'd2, 5);

    // MTHI then MTLO on consecutive cycles.
    @(negedge clk);
    ex_valid = 1'b1; ex_op = 3'b011; ex_rs_val = 32'h1234_5678;
    #1;
    chk("mthi_stall", 64'(ex_stall), 64'd0);
    m_hi = 32'h1234_5678;
    sb_q.push_back({m_hi, m_lo});
    @(negedge clk);
    ex_op = 3'b100; ex_rs_val = 32'hCAFE_BABE;
    #1;
    chk("mtlo_stall", 64'(ex_stall), 64'd0);
    sb_check("mthi_hilo");
    m_lo = 32'hCAFE_BABE;
    sb_q.push_back({m_hi, m_lo});
    @(negedge clk);
    ex_valid = 1'b0; ex_op = 3'b000;
    #1;
    sb_check("mtlo_hilo");

    // Flushed MTHI and an unused encoding leave HI/LO alone.
    @(negedge clk);
    ex_valid = 1'b1; ex_op = 3'b011; ex_rs_val = 32'h0BAD_0BAD; ex_flush = 1'b1;
    #1;
    chk("flush_mthi_stall", 64'(ex_stall), 64'd0);
    @(negedge clk);
    ex_flush = 1'b0; ex_op = 3'b111;
    #1;
    chk("flush_mthi_hilo", {hi, lo}, {m_hi, m_lo});
    chk("op111_stall", 64'(ex_stall), 64'd0);
    @(negedge clk);
    ex_valid = 1'b0; ex_op = 3'b000;
    #1;
    chk("op111_hilo", {hi, lo}, {m_hi, m_lo});
    chk("op111_busy", 64'(busy), 64'd0);

    // Flush in the 10th BUSY cycle, stale div_end during ABORT, DIV waiting through ABORT.
    @(negedge clk);
    ex_valid = 1'b1; ex_op = 3'b001; ex_rs_val = 32'd1000; ex_rt_val = 32'd3;
    #1;
    chk("ab_stall_t", 64'(ex_stall), 64'd1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 10) ex_flush = 1'b1;
      #1;
      if (k == 10) chk("ab_flush_stall", 64'(ex_stall), 64'd0);
    end
    @(negedge clk);
    ex_flush = 1'b0; ex_valid = 1'b0; ex_op = 3'b000;
    div_end = 1'b1; div_product = 64'h1111_1111_2222_2222;
    #1;
    chk("ab1_begin", 64'(div_begin), 64'd0);
    chk("ab1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    div_end = 1'b0; div_product = 64'd0;
    ex_valid = 1'b1; ex_op = 3'b001; ex_rs_val = 32'd1000; ex_rt_val = 32'd7;
    #1;
    chk("ab2_stall", 64'(ex_stall), 64'd1);
    chk("ab2_hilo", {hi, lo}, {m_hi, m_lo});
    chk("ab2_begin", 64'(div_begin), 64'd0);
    @(negedge clk);
    #1;
    chk("ab_idle_busy", 64'(busy), 64'd0);
    chk("ab_idle_stall", 64'(ex_stall), 64'd1);
    finish_div("after_ab", 1'b0, 32'd1000, 32'd7, 4);

    // div_end and flush in the same BUSY cycle: flush wins.
    @(negedge clk);
    ex_valid = 1'b1; ex_op = 3'b010; ex_rs_val = 32'h80; ex_rt_val = 32'h10;
    #1;
    chk("both_stall_t", 64'(ex_stall), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 3) begin
        ex_flush = 1'b1;
        div_end = 1'b1;
        div_product = div_ref(div_unsigned, div_op1, div_op2);
      end
      #1;
      if (k == 3) chk("both_stall", 64'(ex_stall), 64'd0);
    end
    @(negedge clk);
    ex_flush = 1'b0; div_end = 1'b0; div_product = 64'd0; ex_valid = 1'b0; ex_op = 3'b000;
    #1;
    chk("both_hilo", {hi, lo}, {m_hi, m_lo});
    chk("both_abort_busy", 64'(busy), 64'd1);
    chk("both_begin", 64'(div_begin), 64'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("both_idle_busy", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of BUSY.
    @(negedge clk);
    ex_valid = 1'b1; ex_op = 3'b001; ex_rs_val = 32'd100; ex_rt_val = 32'd7;
    #1;
    chk("mrst_stall_t", 64'(ex_stall), 64'd1);
    repeat (5) @(negedge clk);
    #1;
    chk("mrst_pre_begin", 64'(div_begin), 64'd1);
    #2 resetn = 1'b0;
    ex_valid = 1'b0; ex_op = 3'b000;
    #1;
    chk("mrst_begin", 64'(div_begin), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_hilo", {hi, lo}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    resetn = 1'b1;
    do_div("post_rst", 1'b0, 32'hFFFF_FF9C, 32'd7, 8);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
